// File: rtl/cb_vm_seq_pkg.sv
// Shared types and timing constants for the covariance-block vector-matrix sequencer.
package cb_vm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_EN    = 3'd2,
        S_WAIT  = 3'd3,
        S_BURST = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Cycles spent with the AGD enabled, and cycles waiting for its base address.
    localparam int unsigned EN_CYC   = 2;
    localparam int unsigned WAIT_CYC = 1;

    // Width of the shared EN/WAIT phase counter.
    localparam int unsigned PH_W = 2;

endpackage

// File: rtl/cb_vm_seq.sv
// Sequencer for the CB vector-matrix AGD: steps the group index, pulses the AGD
// enable per group, captures the returned base and issues a read burst per group.
module cb_vm_seq
    import cb_vm_seq_pkg::*;
#(
    parameter int unsigned CB_AW     = 17,
    parameter int unsigned ROW_LEN   = 10,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ROW_LEN-1:0] num_groups,
    output logic               agd_en,
    output logic [ROW_LEN-1:0] agd_group_cnt,
    input  logic [CB_AW-1:0]   agd_base_addr,
    output logic [CB_AW-1:0]   rd_addr,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               rd_last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned        BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [PH_W-1:0]    EN_LAST   = PH_W'(EN_CYC - 1);
    localparam logic [PH_W-1:0]    WAIT_LAST = PH_W'(WAIT_CYC - 1);

    state_t             state_q, state_d;
    logic [ROW_LEN-1:0] ngroups_q, ngroups_d;
    logic [ROW_LEN-1:0] group_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [CB_AW-1:0]   base_q, base_d;

    logic               agd_en_d;
    logic [CB_AW-1:0]   rd_addr_d;
    logic               rd_valid_d;
    logic               rd_last_d;
    logic               busy_d;
    logic               done_d;

    // Next-state, counter and next-output computation; outputs are then registered.
    always_comb begin
        state_d   = state_q;
        ngroups_d = ngroups_q;
        group_d   = agd_group_cnt;
        beat_d    = beat_q;
        ph_d      = ph_q;
        base_d    = base_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_groups != '0) begin
                        ngroups_d = num_groups;
                        group_d   = '0;
                        state_d   = S_SETUP;
                    end else begin
                        state_d   = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                ph_d    = '0;
                state_d = S_EN;
            end
            S_EN: begin
                if (ph_q == EN_LAST) begin
                    ph_d    = '0;
                    state_d = S_WAIT;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (ph_q == WAIT_LAST) begin
                    ph_d    = '0;
                    base_d  = agd_base_addr;
                    beat_d  = '0;
                    state_d = S_BURST;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_BURST: begin
                if (rd_valid && rd_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (agd_group_cnt + 1'b1 == ngroups_q) begin
                            state_d = S_DONE;
                        end else begin
                            group_d = agd_group_cnt + 1'b1;
                            state_d = S_SETUP;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops straight to idle; the group index keeps its last value
        // because it only clears on reset or an accepted start.
        if (abort) begin
            state_d = S_IDLE;
            group_d = agd_group_cnt;
            beat_d  = '0;
            ph_d    = '0;
        end

        agd_en_d   = (state_d == S_EN);
        rd_valid_d = (state_d == S_BURST);
        rd_addr_d  = rd_valid_d ? (base_d + CB_AW'(beat_d)) : '0;
        rd_last_d  = rd_valid_d && (beat_d == LAST_BEAT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State, counters, base register and registered outputs.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            ngroups_q     <= '0;
            agd_group_cnt <= '0;
            beat_q        <= '0;
            ph_q          <= '0;
            base_q        <= '0;
            agd_en        <= 1'b0;
            rd_addr       <= '0;
            rd_valid      <= 1'b0;
            rd_last       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            ngroups_q     <= ngroups_d;
            agd_group_cnt <= group_d;
            beat_q        <= beat_d;
            ph_q          <= ph_d;
            base_q        <= base_d;
            agd_en        <= agd_en_d;
            rd_addr       <= rd_addr_d;
            rd_valid      <= rd_valid_d;
            rd_last       <= rd_last_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_cb_vm_seq.sv
// Self-checking bench for cb_vm_seq with a reference AGD model and a read-address scoreboard.
module tb_cb_vm_seq;

    localparam int unsigned CB_AW     = 17;
    localparam int unsigned ROW_LEN   = 10;
    localparam int unsigned BURST_LEN = 4;
    localparam logic [CB_AW-1:0] STRIDE = 17'd37;

    logic               clk = 1'b0;
    logic               sys_rst;
    logic               start;
    logic               abort;
    logic [ROW_LEN-1:0] num_groups;
    logic               agd_en;
    logic [ROW_LEN-1:0] agd_group_cnt;
    logic [CB_AW-1:0]   agd_base_addr;
    logic [CB_AW-1:0]   rd_addr;
    logic               rd_valid;
    logic               rd_ready;
    logic               rd_last;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    logic [CB_AW-1:0] base0;
    logic [CB_AW-1:0] exp_q[$];
    int accepted  = 0;
    int done_cnt  = 0;
    int en_cnt    = 0;
    int stall_cnt = 0;
    int beat_idx  = 0;
    logic             prev_stall = 1'b0;
    logic [CB_AW-1:0] prev_addr  = '0;

    cb_vm_seq #(
        .CB_AW    (CB_AW),
        .ROW_LEN  (ROW_LEN),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .abort        (abort),
        .num_groups   (num_groups),
        .agd_en       (agd_en),
        .agd_group_cnt(agd_group_cnt),
        .agd_base_addr(agd_base_addr),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference AGD: base address is an affine function of the group index.
    assign agd_base_addr = base0 + CB_AW'(agd_group_cnt) * STRIDE;

    // Scoreboard consumer: every accepted beat pops and checks the next expected address.
    always @(negedge clk) begin
        if (sys_rst) begin
            prev_stall = 1'b0;
            beat_idx   = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (rd_addr !== prev_addr) begin
                    bad++;
                    $display("FAIL stall_hold: rd_addr=%0d held=%0d", rd_addr, prev_addr);
                end
            end
            if (rd_valid && rd_ready) begin
                logic [CB_AW-1:0] e;
                accepted++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: rd_addr=%0d with empty scoreboard", rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_addr !== e) begin
                        bad++;
                        $display("FAIL beat_addr: rd_addr=%0d expected=%0d", rd_addr, e);
                    end
                end
                total++;
                if (rd_last !== (beat_idx == BURST_LEN - 1)) begin
                    bad++;
                    $display("FAIL beat_last: rd_last=%0b expected=%0b", rd_last, beat_idx == BURST_LEN - 1);
                end
                beat_idx = (beat_idx + 1) % BURST_LEN;
            end
            if (rd_valid && !rd_ready) stall_cnt++;
            prev_stall = rd_valid && !rd_ready;
            prev_addr  = rd_addr;
            if (done)   done_cnt++;
            if (agd_en) en_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in cycle 0 and loads the scoreboard; returns in cycle 1.
    task automatic drive_start(input int ng);
        logic [CB_AW-1:0] a;
        for (int g = 0; g < ng; g++) begin
            for (int b = 0; b < BURST_LEN; b++) begin
                a = base0 + CB_AW'(g) * STRIDE + CB_AW'(b);
                exp_q.push_back(a);
            end
        end
        num_groups = ROW_LEN'(ng);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle_ready, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (toggle_ready) rd_ready = ~rd_ready;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; start = 1'b0; abort = 1'b0; num_groups = '0; rd_ready = 1'b1; base0 = '0;
        #2;
        total++;
        if ({agd_en, rd_valid, rd_last, busy, done} !== 5'b0 || rd_addr !== '0 || agd_group_cnt !== '0) begin
            bad++;
            $display("FAIL reset_outputs: en/val/last/busy/done=%b addr=%0d grp=%0d required all 0",
                     {agd_en, rd_valid, rd_last, busy, done}, rd_addr, agd_group_cnt);
        end
        tick(); tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [4:0] obs, exp;
        base0 = 17'd100;
        drive_start(1);
        for (int k = 1; k <= 10; k++) begin
            obs = {busy, agd_en, rd_valid, rd_last, done};
            exp = {k <= 9, k == 2 || k == 3, k >= 5 && k <= 8, k == 8, k == 9};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single_cycle%0d: busy/en/val/last/done=%b required=%b", k, obs, exp);
            end
            if (k >= 5 && k <= 8) begin
                total++;
                if (rd_addr !== CB_AW'(100 + k - 5)) begin
                    bad++;
                    $display("FAIL single_addr%0d: rd_addr=%0d required=%0d", k, rd_addr, 100 + k - 5);
                end
            end
            tick();
        end
    endtask

    task automatic test_multi();
        int acc0, done0, next_g;
        bit prev_en, got;
        base0 = 17'd5000;
        acc0 = accepted; done0 = done_cnt; next_g = 0; prev_en = 1'b0;
        drive_start(3);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (agd_en && !prev_en) begin
                total++;
                if (agd_group_cnt !== ROW_LEN'(next_g)) begin
                    bad++;
                    $display("FAIL multi_group: agd_group_cnt=%0d required=%0d", agd_group_cnt, next_g);
                end
                next_g++;
            end
            prev_en = agd_en;
            if (done) got = 1'b1;
            tick();
        end
        tick(); tick();
        total++;
        if (!got || next_g != 3 || accepted - acc0 != 12 || done_cnt - done0 != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL multi_summary: done_seen=%0b groups=%0d beats=%0d dones=%0d left=%0d required 1/3/12/1/0",
                     got, next_g, accepted - acc0, done_cnt - done0, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int acc0, st0;
        bit got;
        base0 = 17'd777;
        acc0 = accepted; st0 = stall_cnt;
        drive_start(2);
        wait_done(200, 1'b1, got);
        rd_ready = 1'b1;
        tick(); tick();
        total++;
        if (!got || accepted - acc0 != 8 || stall_cnt == st0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL backpressure: done_seen=%0b beats=%0d stalls=%0d left=%0d required 1/8/>0/0",
                     got, accepted - acc0, stall_cnt - st0, exp_q.size());
        end
    endtask

    task automatic test_zero();
        int en0, done0;
        en0 = en_cnt; done0 = done_cnt;
        drive_start(0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b in cycle 1 required 1/1", done, busy);
        end
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (en_cnt != en0 || done_cnt - done0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_quiet: agd_en_cycles=%0d dones=%0d busy=%b required 0/1/0",
                     en_cnt - en0, done_cnt - done0, busy);
        end
    endtask

    task automatic test_abort();
        int done0;
        done0 = done_cnt;
        base0 = 17'd300;
        drive_start(2);
        tick();
        total++;
        if (agd_en !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: agd_en=%b in cycle 2 required 1", agd_en);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({agd_en, rd_valid, rd_last, busy, done} !== 5'b0 || rd_addr !== '0) begin
            bad++;
            $display("FAIL abort_idle: en/val/last/busy/done=%b addr=%0d required all 0",
                     {agd_en, rd_valid, rd_last, busy, done}, rd_addr);
        end
        for (int i = 0; i < 12; i++) tick();
        total++;
        if (done_cnt != done0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_nodone: dones=%0d busy=%b required 0/0", done_cnt - done0, busy);
        end
        exp_q.delete();
    endtask

    task automatic test_start_busy();
        int acc0, done0, done_at;
        base0 = 17'd2000;
        acc0 = accepted; done0 = done_cnt; done_at = -1;
        drive_start(2);
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) begin start = 1'b1; num_groups = 10'd5; end
            if (k == 7) begin start = 1'b0; num_groups = 10'd0; end
            if (done && done_at < 0) done_at = k;
            tick();
        end
        total++;
        if (done_at != 17 || done_cnt - done0 != 1 || accepted - acc0 != 8 || busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL start_busy: done_cycle=%0d dones=%0d beats=%0d busy=%b left=%0d required 17/1/8/0/0",
                     done_at, done_cnt - done0, accepted - acc0, busy, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [CB_AW-1:0] want[4];
        want[0] = 17'd131070; want[1] = 17'd131071; want[2] = 17'd0; want[3] = 17'd1;
        base0 = 17'd131070;
        drive_start(1);
        for (int k = 1; k <= 9; k++) begin
            if (k >= 5 && k <= 8) begin
                total++;
                if (rd_valid !== 1'b1 || rd_addr !== want[k-5]) begin
                    bad++;
                    $display("FAIL wrap_addr%0d: valid=%b rd_addr=%0d required 1/%0d", k, rd_valid, rd_addr, want[k-5]);
                end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit hit;
        base0 = 17'd40;
        drive_start(3);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (rd_valid && agd_group_cnt == 10'd2) hit = 1'b1;
            else tick();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rstmid_reach: group 2 burst seen=%0b required 1", hit);
        end
        sys_rst = 1'b1;
        #1;
        total++;
        if ({agd_en, rd_valid, rd_last, busy, done} !== 5'b0 || rd_addr !== '0 || agd_group_cnt !== '0) begin
            bad++;
            $display("FAIL rstmid_drop: en/val/last/busy/done=%b addr=%0d grp=%0d required all 0",
                     {agd_en, rd_valid, rd_last, busy, done}, rd_addr, agd_group_cnt);
        end
        exp_q.delete();
        tick(); tick();
        sys_rst = 1'b0;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_idle: busy=%b rd_valid=%b required 0/0", busy, rd_valid);
        end
        base0 = 17'd900;
        drive_start(1);
        tick();
        total++;
        if (agd_group_cnt !== '0 || agd_en !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_restart: grp=%0d agd_en=%b required 0/1", agd_group_cnt, agd_en);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_abort();
        test_start_busy();
        test_wrap();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_scoreboard: left=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
